// File: rtl/uart_rx_tx_cfg.sv
// Full-duplex UART with parametrised data/timer width and run-time parity/stop config.
// Tx and Rx share one free-running oversample timer (16 ticks per bit).
module uart_rx_tx_cfg #(
  parameter int DBIT        = 8,
  parameter int TIMER_BITS  = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [TIMER_BITS-1:0] timer_final_value,
  input  logic [1:0]            cfg_parity,
  input  logic                  cfg_stop2,
  input  logic [DBIT-1:0]       tx_din,
  input  logic                  tx_start,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tick,
  input  logic                  rx,
  output logic [DBIT-1:0]       rx_dout,
  output logic                  rx_done_tick,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [3:0] LAST_BIT = 4'(DBIT - 1);

  logic [TIMER_BITS-1:0] timer_cnt;
  logic                  tick;

  // >= rather than == so lowering timer_final_value at run time cannot strand the counter
  assign tick = (timer_cnt >= timer_final_value);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  timer_cnt <= '0;
    else if (tick) timer_cnt <= '0;
    else           timer_cnt <= timer_cnt + 1'b1;
  end

  logic [2:0]      tx_state;
  logic [4:0]      tx_scnt;
  logic [3:0]      tx_ncnt;
  logic [DBIT-1:0] tx_shreg;
  logic            tx_par_en;
  logic            tx_par_bit;
  logic            tx_stop2;
  logic            tx_last_stop;

  assign tx_last_stop = tx_stop2 ? (tx_scnt == 5'd31) : (tx_scnt == 5'd15);
  assign tx_done_tick = (tx_state == S_STOP) && tick && tx_last_stop;
  assign tx_busy      = (tx_state != S_IDLE);

  always_comb begin
    tx = 1'b1;
    case (tx_state)
      S_START:  tx = 1'b0;
      S_DATA:   tx = tx_shreg[0];
      S_PARITY: tx = tx_par_bit;
      default:  tx = 1'b1;
    endcase
  end

  // Everything the frame needs is captured at launch so later input changes cannot corrupt it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state   <= S_IDLE;
      tx_scnt    <= '0;
      tx_ncnt    <= '0;
      tx_shreg   <= '0;
      tx_par_en  <= 1'b0;
      tx_par_bit <= 1'b0;
      tx_stop2   <= 1'b0;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (tx_start) begin
            tx_state   <= S_START;
            tx_scnt    <= '0;
            tx_ncnt    <= '0;
            tx_shreg   <= tx_din;
            tx_par_en  <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            tx_par_bit <= (^tx_din) ^ (cfg_parity == 2'b10);
            tx_stop2   <= cfg_stop2;
          end
        end
        S_START: begin
          if (tick) begin
            if (tx_scnt == 5'd15) begin
              tx_scnt  <= '0;
              tx_state <= S_DATA;
            end else begin
              tx_scnt <= tx_scnt + 5'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (tx_scnt == 5'd15) begin
              tx_scnt  <= '0;
              tx_shreg <= tx_shreg >> 1;
              if (tx_ncnt == LAST_BIT) tx_state <= tx_par_en ? S_PARITY : S_STOP;
              else                     tx_ncnt  <= tx_ncnt + 4'd1;
            end else begin
              tx_scnt <= tx_scnt + 5'd1;
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            if (tx_scnt == 5'd15) begin
              tx_scnt  <= '0;
              tx_state <= S_STOP;
            end else begin
              tx_scnt <= tx_scnt + 5'd1;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (tx_last_stop) begin
              tx_scnt  <= '0;
              tx_state <= S_IDLE;
            end else begin
              tx_scnt <= tx_scnt + 5'd1;
            end
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rx_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_sync <= '1;
    else          rx_sync <= {rx_sync[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = rx_sync[SYNC_STAGES-1];

  logic [2:0]      rx_state;
  logic [3:0]      rx_scnt;
  logic [3:0]      rx_ncnt;
  logic [DBIT-1:0] rx_shreg;
  logic            rx_par_en;
  logic            rx_par_odd;
  logic            rx_par_sample;

  // Start is re-checked at tick 7 (mid-bit); every later sample is 16 ticks on, so all land mid-bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state      <= S_IDLE;
      rx_scnt       <= '0;
      rx_ncnt       <= '0;
      rx_shreg      <= '0;
      rx_par_en     <= 1'b0;
      rx_par_odd    <= 1'b0;
      rx_par_sample <= 1'b0;
      rx_dout       <= '0;
      rx_done_tick  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (!rx_s) begin
            rx_state   <= S_START;
            rx_scnt    <= '0;
            rx_par_en  <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            rx_par_odd <= (cfg_parity == 2'b10);
          end
        end
        S_START: begin
          if (tick) begin
            if (rx_scnt == 4'd7) begin
              rx_scnt  <= '0;
              rx_ncnt  <= '0;
              rx_state <= rx_s ? S_IDLE : S_DATA;
            end else begin
              rx_scnt <= rx_scnt + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (rx_scnt == 4'd15) begin
              rx_scnt  <= '0;
              rx_shreg <= {rx_s, rx_shreg[DBIT-1:1]};
              if (rx_ncnt == LAST_BIT) rx_state <= rx_par_en ? S_PARITY : S_STOP;
              else                     rx_ncnt  <= rx_ncnt + 4'd1;
            end else begin
              rx_scnt <= rx_scnt + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            if (rx_scnt == 4'd15) begin
              rx_scnt       <= '0;
              rx_par_sample <= rx_s;
              rx_state      <= S_STOP;
            end else begin
              rx_scnt <= rx_scnt + 4'd1;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (rx_scnt == 4'd15) begin
              rx_scnt       <= '0;
              rx_done_tick  <= 1'b1;
              rx_dout       <= rx_shreg;
              rx_frame_err  <= ~rx_s;
              rx_parity_err <= rx_par_en && (rx_par_sample != ((^rx_shreg) ^ rx_par_odd));
              rx_state      <= S_IDLE;
            end else begin
              rx_scnt <= rx_scnt + 4'd1;
            end
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_tx_cfg.sv
// Directed bench for uart_rx_tx_cfg: loopback frames, injected rx errors, glitches, mid-frame reset.
// timer_final_value=3 -> 4 clocks per tick, 64 clocks per bit.
module tb_uart_rx_tx_cfg;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] timer_final_value = 11'd3;
  logic [1:0]  cfg_parity = 2'b00;
  logic        cfg_stop2 = 1'b0;
  logic [7:0]  tx_din = 8'h00;
  logic        tx_start = 1'b0;
  logic        tx;
  logic        tx_busy;
  logic        tx_done_tick;
  logic        rx_line;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b1;
  logic [7:0]  rx_dout;
  logic        rx_done_tick;
  logic        rx_parity_err;
  logic        rx_frame_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rx_count = 0;
  logic [7:0] last_dout = 8'h00;
  logic last_perr = 1'b0;
  logic last_ferr = 1'b0;
  int busy_cycles;
  int done_at;
  logic line_mid [0:31];

  assign rx_line = loop_en ? tx : rx_drv;

  uart_rx_tx_cfg dut (
    .clk(clk), .reset_n(reset_n), .timer_final_value(timer_final_value),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .tx_din(tx_din), .tx_start(tx_start),
    .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick), .rx(rx_line),
    .rx_dout(rx_dout), .rx_done_tick(rx_done_tick),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err)
  );

  always #5 clk = ~clk;

  // Tracks the DUT baud timer phase: timer value == cyc % 4 while timer_final_value stays 3
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) begin
      rx_count  = rx_count + 1;
      last_dout = rx_dout;
      last_perr = rx_parity_err;
      last_ferr = rx_frame_err;
    end
  end

  task automatic launch_frame(input logic [7:0] d, input logic [1:0] par, input logic s2);
    cfg_parity = par;
    cfg_stop2  = s2;
    tx_din     = d;
    @(negedge clk);
    while (cyc % 4 != 3) @(negedge clk);
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic watch_frame;
    int i;
    for (int k = 0; k < 32; k++) line_mid[k] = 1'bx;
    done_at = -1;
    i = 0;
    while (tx_busy === 1'b1 && i < 2000) begin
      if (i % 64 == 32) line_mid[i/64] = tx;
      if (tx_done_tick === 1'b1) done_at = i;
      if (i == 100) begin
        tx_din     = ~tx_din;
        cfg_parity = cfg_parity ^ 2'b11;
        cfg_stop2  = ~cfg_stop2;
      end
      i++;
      @(negedge clk);
    end
    busy_cycles = i;
  endtask

  task automatic send_rx_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                               input logic stop_bit);
    int n;
    int c0;
    rx_drv = 1'b0;
    repeat (64) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      rx_drv = d[b];
      repeat (64) @(negedge clk);
    end
    if (par_en) begin
      rx_drv = par_bit;
      repeat (64) @(negedge clk);
    end
    rx_drv = stop_bit;
    c0 = rx_count;
    n = 0;
    while (rx_count == c0 && n < 128) begin
      @(negedge clk);
      n++;
    end
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx got=%b exp=1", tx); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", tx_busy); end
    total++; if (tx_done_tick !== 1'b0) begin bad++; $display("[TB] FAIL reset_txdone got=%b exp=0", tx_done_tick); end
    total++; if (rx_dout !== 8'h00) begin bad++; $display("[TB] FAIL reset_dout got=%h exp=00", rx_dout); end
    total++; if (rx_done_tick !== 1'b0) begin bad++; $display("[TB] FAIL reset_rxdone got=%b exp=0", rx_done_tick); end
    total++; if (rx_parity_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_perr got=%b exp=0", rx_parity_err); end
    total++; if (rx_frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_ferr got=%b exp=0", rx_frame_err); end
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_8n1;
    int c0;
    loop_en = 1'b1;
    c0 = rx_count;
    launch_frame(8'h7E, 2'b00, 1'b0);
    watch_frame();
    total++; if (busy_cycles != 640) begin bad++; $display("[TB] FAIL 8n1_busy_len got=%0d exp=640", busy_cycles); end
    total++; if (done_at != 639) begin bad++; $display("[TB] FAIL 8n1_done_pos got=%0d exp=639", done_at); end
    total++; if (line_mid[0] !== 1'b0 || line_mid[1] !== 1'b0 || line_mid[2] !== 1'b1)
      begin bad++; $display("[TB] FAIL 8n1_line got=%b%b%b exp=001", line_mid[0], line_mid[1], line_mid[2]); end
    total++; if (rx_count != c0 + 1) begin bad++; $display("[TB] FAIL 8n1_rx_count got=%0d exp=%0d", rx_count, c0 + 1); end
    total++; if (last_dout !== 8'h7E) begin bad++; $display("[TB] FAIL 8n1_dout got=%h exp=7e", last_dout); end
    total++; if (last_perr !== 1'b0 || last_ferr !== 1'b0)
      begin bad++; $display("[TB] FAIL 8n1_errs got=%b%b exp=00", last_perr, last_ferr); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_even_parity;
    int c0;
    loop_en = 1'b1;
    c0 = rx_count;
    launch_frame(8'hA5, 2'b01, 1'b0);
    watch_frame();
    total++; if (line_mid[9] !== 1'b0) begin bad++; $display("[TB] FAIL even_par_bit got=%b exp=0", line_mid[9]); end
    total++; if (line_mid[10] !== 1'b1) begin bad++; $display("[TB] FAIL even_stop got=%b exp=1", line_mid[10]); end
    total++; if (busy_cycles != 704) begin bad++; $display("[TB] FAIL even_busy_len got=%0d exp=704", busy_cycles); end
    total++; if (rx_count != c0 + 1 || last_dout !== 8'hA5)
      begin bad++; $display("[TB] FAIL even_loop_dout got=%h n=%0d exp=a5 n=%0d", last_dout, rx_count, c0 + 1); end
    total++; if (last_perr !== 1'b0) begin bad++; $display("[TB] FAIL even_loop_perr got=%b exp=0", last_perr); end
    repeat (20) @(negedge clk);
    loop_en    = 1'b0;
    cfg_parity = 2'b01;
    c0 = rx_count;
    send_rx_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    total++; if (rx_count != c0 + 1) begin bad++; $display("[TB] FAIL bad_par_count got=%0d exp=%0d", rx_count, c0 + 1); end
    total++; if (last_perr !== 1'b1) begin bad++; $display("[TB] FAIL bad_par_perr got=%b exp=1", last_perr); end
    total++; if (last_dout !== 8'hA5) begin bad++; $display("[TB] FAIL bad_par_dout got=%h exp=a5", last_dout); end
    total++; if (last_ferr !== 1'b0) begin bad++; $display("[TB] FAIL bad_par_ferr got=%b exp=0", last_ferr); end
  endtask

  task automatic test_odd_stop2;
    int c0;
    loop_en = 1'b1;
    c0 = rx_count;
    launch_frame(8'h01, 2'b10, 1'b1);
    watch_frame();
    total++; if (line_mid[9] !== 1'b0) begin bad++; $display("[TB] FAIL odd_par_bit got=%b exp=0", line_mid[9]); end
    total++; if (line_mid[10] !== 1'b1 || line_mid[11] !== 1'b1)
      begin bad++; $display("[TB] FAIL odd_stop2_line got=%b%b exp=11", line_mid[10], line_mid[11]); end
    total++; if (busy_cycles != 768) begin bad++; $display("[TB] FAIL odd_busy_len got=%0d exp=768", busy_cycles); end
    total++; if (done_at != 767) begin bad++; $display("[TB] FAIL odd_done_pos got=%0d exp=767", done_at); end
    total++; if (rx_count != c0 + 1 || last_dout !== 8'h01)
      begin bad++; $display("[TB] FAIL odd_loop_dout got=%h n=%0d exp=01 n=%0d", last_dout, rx_count, c0 + 1); end
    total++; if (last_perr !== 1'b0 || last_ferr !== 1'b0)
      begin bad++; $display("[TB] FAIL odd_loop_errs got=%b%b exp=00", last_perr, last_ferr); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_frame_err;
    int c0;
    loop_en    = 1'b0;
    cfg_parity = 2'b00;
    c0 = rx_count;
    send_rx_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    total++; if (rx_count != c0 + 1) begin bad++; $display("[TB] FAIL ferr_count got=%0d exp=%0d", rx_count, c0 + 1); end
    total++; if (last_ferr !== 1'b1) begin bad++; $display("[TB] FAIL ferr_flag got=%b exp=1", last_ferr); end
    total++; if (last_dout !== 8'h3C) begin bad++; $display("[TB] FAIL ferr_dout got=%h exp=3c", last_dout); end
    send_rx_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    total++; if (last_ferr !== 1'b0) begin bad++; $display("[TB] FAIL ferr_clear got=%b exp=0", last_ferr); end
    total++; if (last_dout !== 8'h5A) begin bad++; $display("[TB] FAIL ferr_next_dout got=%h exp=5a", last_dout); end
  endtask

  task automatic test_glitch;
    int c0;
    loop_en    = 1'b0;
    cfg_parity = 2'b00;
    c0 = rx_count;
    rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    total++; if (rx_count != c0) begin bad++; $display("[TB] FAIL glitch_ignored got=%0d exp=%0d", rx_count, c0); end
    send_rx_frame(8'h96, 1'b0, 1'b0, 1'b1);
    total++; if (rx_count != c0 + 1) begin bad++; $display("[TB] FAIL glitch_next_count got=%0d exp=%0d", rx_count, c0 + 1); end
    total++; if (last_dout !== 8'h96 || last_ferr !== 1'b0)
      begin bad++; $display("[TB] FAIL glitch_next_dout got=%h/%b exp=96/0", last_dout, last_ferr); end
  endtask

  task automatic test_reset_mid;
    int c0;
    loop_en = 1'b1;
    launch_frame(8'h55, 2'b00, 1'b0);
    repeat (200) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("[TB] FAIL midrst_tx got=%b exp=1", tx); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got=%b exp=0", tx_busy); end
    total++; if (tx_done_tick !== 1'b0) begin bad++; $display("[TB] FAIL midrst_txdone got=%b exp=0", tx_done_tick); end
    total++; if (rx_dout !== 8'h00) begin bad++; $display("[TB] FAIL midrst_dout got=%h exp=00", rx_dout); end
    total++; if (rx_done_tick !== 1'b0) begin bad++; $display("[TB] FAIL midrst_rxdone got=%b exp=0", rx_done_tick); end
    total++; if (rx_parity_err !== 1'b0 || rx_frame_err !== 1'b0)
      begin bad++; $display("[TB] FAIL midrst_errs got=%b%b exp=00", rx_parity_err, rx_frame_err); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    c0 = rx_count;
    launch_frame(8'hC3, 2'b00, 1'b0);
    watch_frame();
    total++; if (busy_cycles != 640) begin bad++; $display("[TB] FAIL post_busy_len got=%0d exp=640", busy_cycles); end
    total++; if (rx_count != c0 + 1) begin bad++; $display("[TB] FAIL post_count got=%0d exp=%0d", rx_count, c0 + 1); end
    total++; if (last_dout !== 8'hC3) begin bad++; $display("[TB] FAIL post_dout got=%h exp=c3", last_dout); end
    total++; if (last_perr !== 1'b0 || last_ferr !== 1'b0)
      begin bad++; $display("[TB] FAIL post_errs got=%b%b exp=00", last_perr, last_ferr); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_even_parity();
    test_odd_stop2();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_tx_cfg.md
Name: uart_rx_tx_cfg

Overview:
Full-duplex UART transmitter and receiver. Data width and timer width are set by parameters; parity and stop-bit count are run-time configuration inputs. The block detects parity and framing errors and rejects start-bit glitches. It is the parametrised successor to the fixed 8N1 core in core/uart and keeps the same Tx/Rx port handshake, so existing loopback benches port over directly.

Parameters:
DBIT, 8, data bits per frame; legal range 5..9; sent and received LSB first.
TIMER_BITS, 11, width of timer_final_value and of the baud timer counter.
SYNC_STAGES, 2, number of flip-flops in the rx input synchroniser (>=2).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
timer_final_value  in  TIMER_BITS  baud timer terminal count; oversample tick period = value+1 clocks; 16 ticks per bit
cfg_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none
cfg_stop2  in  1  1 = Tx sends two stop bits
tx_din  in  DBIT  transmit data
tx_start  in  1  transmit request, level-sensitive
tx  out  1  serial output
tx_busy  out  1  high from frame launch until tx_done_tick
tx_done_tick  out  1  one-clock pulse at end of last stop bit
rx  in  1  serial input, asynchronous
rx_dout  out  DBIT  last received data word
rx_done_tick  out  1  one-clock pulse; rx_dout and error flags valid this cycle
rx_parity_err  out  1  parity mismatch on last frame; held until next rx_done_tick
rx_frame_err  out  1  stop bit sampled low on last frame; held until next rx_done_tick

Behaviour:
- Reset (async, any time, including mid-frame): tx=1, tx_busy=0, tx_done_tick=0, rx_dout=0, rx_done_tick=0, both error flags 0, both FSMs to IDLE, baud timer=0, synchroniser preset to 1.
- Baud timer: free-running, counts 0..timer_final_value, then wraps to 0. tick=1 for one clock on the wrap. Tx and Rx share the timer. A timer_final_value of 0 gives a tick every clock.
- Tx FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If tx_start=1, latch tx_din, cfg_parity and cfg_stop2; go to START; tx_busy rises the next clock.
  - START: tx=0 for 16 ticks.
  - DATA: DBIT bits, LSB first, 16 ticks each.
  - PARITY: entered only when parity is enabled. Sends even parity = XOR of data, or odd parity = its inverse; 16 ticks.
  - STOP: tx=1 for 16 ticks (32 if cfg_stop2 latched). On the last tick, pulse tx_done_tick, drop tx_busy, return to IDLE.
  - tx_start while busy is ignored. tx_start held high launches back-to-back frames with one idle clock between them.
  - Config or tx_din changes mid-frame have no effect on the frame in flight.
- Rx FSM states: IDLE, START, DATA, PARITY, STOP. It operates on the synchronised rx signal.
  - IDLE: a low level moves to START and resets the tick count. Latch cfg_parity at this point.
  - START: at tick count 7 (mid-bit), sample. If the sample is 1, treat it as a glitch and return to IDLE with no outputs. If it is 0, go to DATA.
  - DATA: sample every 16 ticks; shift in LSB first.
  - PARITY: if enabled, sample and compare against XOR of data (even) or its inverse (odd).
  - STOP: sample the first stop bit at mid-bit. In that same clock: pulse rx_done_tick, update rx_dout, set rx_frame_err = ~sample and rx_parity_err = mismatch (0 if parity is none); then return to IDLE.
  - The receiver checks only one stop bit regardless of config. A low level seen after returning to IDLE begins a new frame.
- Frame length in clocks = (timer_final_value+1) × 16 × (1 + DBIT + parity + stop bits).

Test Plan:
- DBIT=8, timer_final_value=3, 8N1 loopback (tx→rx), tx_din=8'h7E → rx_done_tick with rx_dout=8'h7E, both errors 0; tx_done_tick exactly 640 clocks after launch.
- cfg_parity=01, tx_din=8'hA5 → parity bit 0 on the line; loopback rx_parity_err=0. Then force the parity bit inverted on rx → rx_parity_err=1, rx_dout=8'hA5.
- cfg_parity=10, cfg_stop2=1, tx_din=8'h01 → parity bit 0, stop high for 32 ticks; tx_busy high throughout, low the clock after tx_done_tick.
- Drive rx with a frame whose stop bit is 0, data 8'h3C → rx_frame_err=1, rx_dout=8'h3C; a following clean frame clears the flag.
- rx low pulse of 4 ticks, then high → no rx_done_tick, Rx FSM back in IDLE; a subsequent valid frame is received correctly.
- Assert reset_n=0 mid-DATA on both Tx and Rx → tx=1 and all outputs 0 immediately; after release, a new 8'hC3 frame loops back correctly.
